// File: rtl/match_resolver_if.sv
// Search-result and responder handshake bundle between the search stage,
// the multiple-response resolver and its downstream consumer.
interface match_resolver_if #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
);
  logic              tag_valid;
  logic [WORDS-1:0]  tag_in;
  logic              abort;
  logic              busy;
  logic              any_match;
  logic [ADDR_W:0]   match_count;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              done;

  modport master (
    output tag_valid, tag_in, abort, out_ready,
    input  busy, any_match, match_count, out_valid, out_addr, out_last, done
  );

  modport slave (
    input  tag_valid, tag_in, abort, out_ready,
    output busy, any_match, match_count, out_valid, out_addr, out_last, done
  );
endinterface

// File: rtl/match_resolver.sv
// Multiple-response resolver: captures a search tag vector and hands out the
// responding word addresses lowest-first over a valid/ready handshake.
module match_resolver #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  match_resolver_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WORDS-1:0]  p_q, p_d;
  logic              any_q, any_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] low_addr;
  logic              one_left;

  function automatic logic [ADDR_W:0] popcount(input logic [WORDS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < WORDS; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [WORDS-1:0] v);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (v[i]) a = ADDR_W'(i);
    end
    return a;
  endfunction

  // Outputs are derived from the registered pending vector, so they hold
  // steady for as long as the consumer stalls.
  assign low_addr = lowest_set(p_q);
  assign one_left = (p_q != '0) && ((p_q & (p_q - 1'b1)) == '0);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    any_d   = any_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.tag_valid) begin
          p_d   = bus.tag_in;
          any_d = |bus.tag_in;
          cnt_d = popcount(bus.tag_in);
          if (bus.tag_in != '0) state_d = SCAN;
          else                  done_d  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          p_d     = '0;
        end else if (bus.out_ready) begin
          // Clearing the lowest set bit retires exactly out_addr.
          p_d = p_q & (p_q - 1'b1);
          if (one_left) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      p_q     <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q == SCAN);
  assign bus.out_valid   = (state_q == SCAN);
  assign bus.out_addr    = low_addr;
  assign bus.out_last    = (state_q == SCAN) && one_left;
  assign bus.any_match   = any_q;
  assign bus.match_count = cnt_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_match_resolver.sv
// Directed bench for match_resolver: expected responder addresses are queued
// at capture time and retired as the resolver hands them out.
module tb_match_resolver;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   q[$];
  int   ncyc;

  match_resolver_if #(.WORDS(32), .ADDR_W(5)) bus ();

  match_resolver #(.WORDS(32), .ADDR_W(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one capture and queue the responders it should produce.
  task automatic capture(input logic [31:0] tags);
    @(negedge clk);
    bus.tag_valid = 1'b1;
    bus.tag_in    = tags;
    for (int i = 0; i < 32; i++) if (tags[i]) q.push_back(i);
    @(negedge clk);
    bus.tag_valid = 1'b0;
    bus.tag_in    = '0;
  endtask

  // Accept every queued responder at full rate, then check the done pulse.
  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && cycles < budget) begin
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_addr", bus.out_addr, q[0]);
      chk("drain_last", bus.out_last, (q.size() == 1));
      void'(q.pop_front());
      @(negedge clk);
      cycles++;
    end
    bus.out_ready = 1'b0;
    chk("drain_timeout_left", q.size(), 0);
    q.delete();
    chk("done_pulse", bus.done, 1);
    chk("busy_after_done", bus.busy, 0);
    chk("valid_after_done", bus.out_valid, 0);
    @(negedge clk);
    chk("done_single", bus.done, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.tag_valid = 1'b0;
    bus.tag_in    = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_any", bus.any_match, 0);
    chk("rst_count", bus.match_count, 0);
    chk("rst_addr", bus.out_addr, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sparse tags, full rate
    capture(32'h8000_0011);
    chk("sparse_busy", bus.busy, 1);
    chk("sparse_any", bus.any_match, 1);
    chk("sparse_count", bus.match_count, 3);
    drain(40, ncyc);
    chk("sparse_cycles", ncyc, 3);

    // Empty search
    capture(32'h0);
    chk("empty_done", bus.done, 1);
    chk("empty_busy", bus.busy, 0);
    chk("empty_valid", bus.out_valid, 0);
    chk("empty_any", bus.any_match, 0);
    chk("empty_count", bus.match_count, 0);
    @(negedge clk);
    chk("empty_done_single", bus.done, 0);
    chk("empty_busy_later", bus.busy, 0);

    // Backpressure
    capture(32'h0000_0006);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_addr", bus.out_addr, 1);
      chk("bp_last", bus.out_last, 0);
      @(negedge clk);
    end
    chk("bp_count", bus.match_count, 2);
    drain(40, ncyc);

    // Ignored capture during SCAN, then abort with a same-cycle handshake
    capture(32'h0000_00F0);
    chk("ab_count", bus.match_count, 4);
    chk("ab_addr0", bus.out_addr, q[0]);
    bus.out_ready = 1'b1;
    bus.tag_valid = 1'b1;
    bus.tag_in    = 32'h0000_0003;
    void'(q.pop_front());
    @(negedge clk);
    chk("ab_addr1", bus.out_addr, q[0]);
    chk("ab_count_hold", bus.match_count, 4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    bus.tag_valid = 1'b0;
    bus.tag_in    = '0;
    q.delete();
    chk("ab_valid", bus.out_valid, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_no_done", bus.done, 0);
    chk("ab_count_kept", bus.match_count, 4);
    chk("ab_any_kept", bus.any_match, 1);
    @(negedge clk);
    chk("ab_no_done_later", bus.done, 0);
    chk("ab_idle_later", bus.busy, 0);

    // All ones
    capture(32'hFFFF_FFFF);
    chk("all_count", bus.match_count, 32);
    drain(40, ncyc);
    chk("all_cycles", ncyc, 32);

    // Reset mid-SCAN
    capture(32'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_addr", bus.out_addr, q[0]);
      void'(q.pop_front());
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("mid_addr3", bus.out_addr, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_any", bus.any_match, 0);
    chk("mid_rst_count", bus.match_count, 0);
    chk("mid_rst_addr", bus.out_addr, 0);
    chk("mid_rst_last", bus.out_last, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_any", bus.any_match, 0);
    chk("post_rst_done", bus.done, 0);

    // Resolver still works after reset
    capture(32'h0000_0100);
    chk("post_count", bus.match_count, 1);
    drain(40, ncyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/match_resolver.md
# match_resolver

Multiple-response resolver for the content-addressable parallel processor. It sits directly downstream of the search stage. It captures the per-word tag (match) vector produced when a masked comparand search completes. It then reports matching word addresses one at a time, lowest address first, over a valid/ready handshake, so later read/write stages can visit each responder in turn. It also publishes a some/none flag and a responder count for the captured vector.

## Interface
- WORDS, default 32: number of CAPP words, which is the tag vector width.
- ADDR_W, default 5: address width; must satisfy 2^ADDR_W >= WORDS.
- CLK  input  1  system clock (16 MHz board clock); all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- tag_valid  input  1  search result strobe; tag_in is captured when tag_valid=1 and busy=0.
- tag_in  input  WORDS  match tags; bit i=1 means word i responded.
- abort  input  1  synchronous cancel of an in-progress resolution.
- busy  output  1  high from the cycle after capture until resolution ends.
- any_match  output  1  OR of the captured tags; valid from the cycle after capture.
- match_count  output  ADDR_W+1  popcount of the captured tags.
- out_valid  output  1  out_addr holds a pending responder.
- out_ready  input  1  consumer accepts the responder.
- out_addr  output  ADDR_W  index of the lowest remaining set tag.
- out_last  output  1  the current out_addr is the final responder.
- done  output  1  one-cycle pulse when resolution completes normally.

## Operation
- States: IDLE, SCAN.
- IDLE:
  - busy=0, out_valid=0.
  - On tag_valid, register tag_in into the pending vector P.
  - Register any_match=|tag_in and match_count=popcount(tag_in).
  - If tag_in≠0, go to SCAN. If tag_in==0, stay in IDLE and pulse done the next cycle.
- SCAN:
  - busy=1, out_valid=1.
  - out_addr is the priority encode of P (lowest set index). It is registered or combinational from the registered P; it must be stable while out_valid=1 and out_ready=0.
  - out_last=1 when P has exactly one set bit.
  - On out_valid and out_ready: clear bit out_addr in P. If out_last, go to IDLE and pulse done.
  - abort=1 in SCAN: go to IDLE, clear P, no done pulse, outputs drop next cycle. abort has priority over a same-cycle handshake. abort in IDLE is ignored.
- tag_valid while busy=1 is ignored; the upstream stage must wait for busy=0.
- any_match and match_count hold their last captured value until the next capture; abort does not clear them.
- Count width ADDR_W+1 holds WORDS (32 needs 6 bits); no saturation needed.

## Timing
- Reset (RST_N=0, asynchronous): state=IDLE, P=0, busy=0, any_match=0, match_count=0, out_valid=0, out_addr=0, out_last=0, done=0.
- Capture at edge N: any_match, match_count, busy and out_valid are valid after edge N, i.e. one cycle of latency.
- Throughput: one responder per cycle when out_ready is held high; K responders take K cycles in SCAN.
- done is high for exactly the one cycle after the final handshake edge, or after an all-zero capture edge. In that same cycle busy=0, so a new tag_valid is accepted that cycle.
- Handshake: out_valid never deasserts without a handshake, except on abort or reset. out_addr and out_last do not change while stalled.
- Reset asserted mid-SCAN: all outputs go immediately to their reset values; no done pulse.

## Test plan
- Reset mid-SCAN: capture 0xFFFF_FFFF, accept 3 responders, then pulse RST_N low. Required: outputs zero immediately; after release, IDLE and busy=0; any_match=0.
- Sparse tags with full rate: tag_in=0x8000_0011, out_ready=1. Required: out_addr sequence 0, 4, 31 on consecutive cycles; out_last only with 31; any_match=1; match_count=3; done one cycle after 31 is accepted.
- Empty search: tag_in=0. Required: out_valid stays 0, any_match=0, match_count=0, done pulses the next cycle, busy never asserts.
- Backpressure: tag_in=0x0000_0006 with out_ready low for 5 cycles. Required: out_addr=1 held stable with out_valid=1; then raise out_ready. Required: 1 then 2, out_last with 2.
- Abort and ignored capture: capture 0x0000_00F0, accept 4, assert abort together with out_ready. Required: next cycle out_valid=0, busy=0, no done; tag_valid raised during SCAN had no effect; match_count still 4.
- All ones: tag_in=0xFFFF_FFFF. Required: match_count=32; addresses 0..31 in order; done exactly 32 cycles after the first out_valid, with out_ready held.
